// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one SRAM read per instruction,
// captures the registered read data and offers it to decode over valid/ready.
// Execute can redirect the PC at any time; a redirect drops any captured or
// in-flight instruction and restarts fetching at the (word-aligned) target.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        sram_enable_o,
  output logic [31:0] sram_addr_o,
  input  logic [31:0] sram_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    VALID
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, ipc_q;
  logic        capture_en;

  // Next-state, next-PC and capture decision; redirect overrides everything.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    capture_en = 1'b0;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        capture_en = 1'b1;
        state_d    = VALID;
      end
      VALID: begin
        if (inst_ready_i) begin
          pc_d    = pc_q + PC_STEP;  // 32-bit modulo: 0xFFFF_FFFC wraps to 0
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    // A redirect wins over a sequential step, discards a response arriving in
    // CAPTURE and clears a presented instruction; the transfer (if any) still
    // happened because decode saw valid && ready at this edge.
    if (redirect_valid_i) begin
      pc_d       = redirect_pc_i & ~32'h0000_0003;
      state_d    = FETCH;
      capture_en = 1'b0;
    end
  end

  // Control state and PC, with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Instruction and PC capture from the SRAM response.
  always_ff @(posedge clk_i) begin
    // NOTE: these data registers are deliberately not reset; they are only
    // observed through outputs gated by state, which is reset.
    if (capture_en) begin
      inst_q <= sram_data_i;
      ipc_q  <= pc_q;
    end
  end

  // Outputs decoded from registered state only; no input-to-output paths.
  assign sram_enable_o = (state_q == FETCH);
  assign sram_addr_o   = (state_q == FETCH) ? pc_q : 32'd0;
  assign inst_valid_o  = (state_q == VALID);
  assign inst_o        = (state_q == VALID) ? inst_q : 32'd0;
  assign pc_o          = (state_q == VALID) ? ipc_q : 32'd0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios followed by random
// ready/redirect/reset traffic, all compared against a timeline model.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sram_enable_o;
  logic [31:0] sram_addr_o;
  logic [31:0] sram_data_i = 32'd0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  int checks = 0;
  int errors = 0;

  ifu_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .sram_enable_o   (sram_enable_o),
    .sram_addr_o     (sram_addr_o),
    .sram_data_i     (sram_data_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SRAM contents: distinct per address, with a known word at the reset PC.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Timeline model: the next fetch is issued in cycle m_fetch_at for address
  // m_pc; that instruction is presented from two cycles later until it is
  // consumed or a redirect/reset replaces the fetch.
  int          cyc = 0;
  int          m_fetch_at = 0;
  logic [31:0] m_pc = RESET_PC;
  bit          m_known = 0;

  // Samples of the most recent cycle (for directed checks).
  logic        s_en, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;

  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    logic        e_en, e_valid;
    logic        was_en;
    logic [31:0] was_addr;
    rst_i = r;
    redirect_valid_i = rv;
    redirect_pc_i = rp;
    inst_ready_i = rdy;
    @(negedge clk_i);
    s_en = sram_enable_o; s_addr = sram_addr_o; s_valid = inst_valid_o;
    s_inst = inst_o; s_pc = pc_o;
    e_en    = (cyc == m_fetch_at);
    e_valid = (cyc >= m_fetch_at + 2);
    if (m_known) begin
      check("sram_enable", {31'd0, s_en}, {31'd0, e_en});
      check("sram_addr", s_addr, e_en ? m_pc : 32'd0);
      check("inst_valid", {31'd0, s_valid}, {31'd0, e_valid});
      check("inst", s_inst, e_valid ? mem(m_pc) : 32'd0);
      check("pc", s_pc, e_valid ? m_pc : 32'd0);
    end
    was_en = sram_enable_o;
    was_addr = sram_addr_o;
    @(posedge clk_i);
    if (r) begin
      m_known = 1;
      m_pc = RESET_PC;
      m_fetch_at = cyc + 2;
    end else if (m_known) begin
      if (rv) begin
        m_pc = rp & ~32'h3;
        m_fetch_at = cyc + 1;
      end else if (e_valid && rdy) begin
        m_pc = m_pc + 32'd4;
        m_fetch_at = cyc + 1;
      end
    end
    #1;
    sram_data_i = was_en ? mem(was_addr) : 32'd0;
    cyc++;
  endtask

  initial begin
    // Reset and first fetch.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("rst_valid", {31'd0, s_valid}, 32'd0);
    check("rst_addr", s_addr, 32'd0);
    check("rst_inst", s_inst, 32'd0);
    check("rst_pc", s_pc, 32'd0);
    step(0, 0, 0, 1);                              // cycle 1: IDLE
    step(0, 0, 0, 1);                              // cycle 2: FETCH
    check("first_addr", s_addr, 32'h8000_0000);
    step(0, 0, 0, 1);                              // cycle 3: CAPTURE
    step(0, 0, 0, 1);                              // cycle 4: VALID, transfer
    check("first_valid", {31'd0, s_valid}, 32'd1);
    check("first_inst", s_inst, 32'h0000_0413);
    check("first_pc", s_pc, 32'h8000_0000);
    step(0, 0, 0, 1);
    check("second_addr", s_addr, 32'h8000_0004);

    // Decode stalls five cycles in VALID.
    step(0, 0, 0, 0);                              // CAPTURE
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      check("stall_pc", s_pc, 32'h8000_0004);
    end
    step(0, 0, 0, 1);                              // transfer
    step(0, 0, 0, 1);
    check("after_stall_addr", s_addr, 32'h8000_0008);

    // Redirect during CAPTURE drops the response.
    step(0, 1, 32'h8000_0102, 1);                  // CAPTURE + redirect
    step(0, 0, 0, 1);
    check("redir_addr", s_addr, 32'h8000_0100);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("redir_pc", s_pc, 32'h8000_0100);

    // Redirect coincident with a transfer.
    step(0, 1, 32'h8000_0010, 1);                  // FETCH + redirect
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'h8000_0200, 1);                  // VALID + transfer + redirect
    check("xfer_redir_pc", s_pc, 32'h8000_0010);
    step(0, 1, 32'hFFFF_FFFC, 1);
    check("xfer_redir_addr", s_addr, 32'h8000_0200);

    // PC wrap at the top of the address space.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("wrap_pc", s_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    check("wrap_addr", s_addr, 32'h0000_0000);

    // Reset pulse while presenting.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("pre_rst_valid", {31'd0, s_valid}, 32'd1);
    step(0, 0, 0, 1);
    check("post_rst_valid", {31'd0, s_valid}, 32'd0);
    step(0, 0, 0, 1);
    check("post_rst_addr", s_addr, RESET_PC);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r, rv, rdy;
      logic [31:0] rp;
      r   = ($urandom_range(199) == 0);
      rv  = ($urandom_range(11) == 0);
      rdy = ($urandom_range(1) == 1);
      rp  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom;
      step(r, rv, rp, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
